// File: rtl/jericalla_pkg.sv
// Shared Jericalla datapath definitions: default word/address widths and the
// register address/data types used by decode, ALU and the register file.
package jericalla_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NRD_MIN    = 1;
  localparam int NRD_MAX    = 4;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  // Largest value the pending counter can reach for a given file shape.
  function automatic int unsigned pend_limit(input int addr_w, input bit zero_reg);
    return (32'd1 << addr_w) - (zero_reg ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/sb_tracker.sv
// Pending-write scoreboard: one busy bit per register plus a registered
// count of busy bits. A set and a clear of the same register resolve to set.
module sb_tracker
  import jericalla_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en,
  input  logic [ADDR_W-1:0]     set_addr,
  input  logic                  clr_en,
  input  logic [ADDR_W-1:0]     clr_addr,
  output logic [2**ADDR_W-1:0]  busy,
  output logic [ADDR_W:0]       pend
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  logic             set_eff;
  logic             same_addr;
  logic             inc;
  logic             dec;
  logic [DEPTH-1:0] busy_nxt;
  logic [ADDR_W:0]  pend_nxt;

  always_comb begin
    set_eff   = set_en && !(ZERO_REG && (set_addr == '0));
    same_addr = set_eff && clr_en && (set_addr == clr_addr);
    inc       = set_eff && !busy[set_addr];
    // A clear overridden by a same-register set does not retire anything.
    dec       = clr_en && busy[clr_addr] && !same_addr;

    busy_nxt = busy;
    if (clr_en)  busy_nxt[clr_addr] = 1'b0;
    if (set_eff) busy_nxt[set_addr] = 1'b1;

    pend_nxt = pend;
    if (inc && !dec)      pend_nxt = pend + ONE;
    else if (dec && !inc) pend_nxt = pend - ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      pend <= '0;
    end else begin
      busy <= busy_nxt;
      pend <= pend_nxt;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with write-through bypass, optional hardwired
// zero register, asynchronous clear and a pending-write scoreboard.
module reg_file_sb
  import jericalla_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*ADDR_W-1:0] RA,
  output logic [NRD*DATA_W-1:0] DR,
  output logic [NRD-1:0]        RBUSY,
  input  logic [ADDR_W-1:0]     WA,
  input  logic [DATA_W-1:0]     WD,
  input  logic                  WE,
  input  logic [ADDR_W-1:0]     SA,
  input  logic                  SE,
  output logic [ADDR_W:0]       PEND
);

  localparam int DEPTH = 2**ADDR_W;

  if (NRD < NRD_MIN || NRD > NRD_MAX) begin : g_bad_nrd
    $error("reg_file_sb: NRD must be in 1..4");
  end

  logic              we_g;
  logic              se_g;
  logic              wr_ok;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;

  // Requests are dead while reset is held, including the bypass path.
  assign we_g  = WE & rst_n;
  assign se_g  = SE & rst_n;
  assign wr_ok = we_g && !(ZERO_REG && (WA == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[WA] <= WD;
    end
  end

  sb_tracker #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (se_g),
    .set_addr (SA),
    .clr_en   (we_g),
    .clr_addr (WA),
    .busy     (busy),
    .pend     (PEND)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              is_zero;
    logic              addr_hit;

    assign ra       = RA[k*ADDR_W +: ADDR_W];
    assign is_zero  = ZERO_REG && (ra == '0);
    assign addr_hit = BYPASS && (WA == ra);

    assign DR[k*DATA_W +: DATA_W] = is_zero              ? '0 :
                                    (addr_hit && wr_ok)  ? WD :
                                    mem[ra];

    // A register being written this cycle is already forwarded, so it is
    // reported as not busy even if a new producer is issued alongside.
    assign RBUSY[k] = !is_zero && !(addr_hit && we_g) && busy[ra];
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed scoreboard bench for reg_file_sb: the driver queues expected
// port values, a monitor samples the DUT and compares them.
module tb_reg_file_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 2;

  localparam int S_DR0 = 0, S_DR1 = 1, S_RB0 = 2, S_RB1 = 3, S_PEND = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NRD*ADDR_W-1:0] ra;
  logic [NRD*DATA_W-1:0] dr;
  logic [NRD-1:0]        rbusy;
  logic [ADDR_W-1:0]     wa;
  logic [DATA_W-1:0]     wd;
  logic                  we;
  logic [ADDR_W-1:0]     sa;
  logic                  se;
  logic [ADDR_W:0]       pend;
  logic [ADDR_W-1:0]     ra0, ra1;

  assign ra = {ra1, ra0};

  logic [DATA_W-1:0] exp_q[$];
  int                sel_q[$];
  string             name_q[$];
  int                n_tests = 0;
  int                n_fail  = 0;
  event              chk_ev;

  // clock / reset
  always #5 clk = ~clk;

  reg_file_sb #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NRD      (NRD),
    .ZERO_REG (1'b1),
    .BYPASS   (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RA    (ra),
    .DR    (dr),
    .RBUSY (rbusy),
    .WA    (wa),
    .WD    (wd),
    .WE    (we),
    .SA    (sa),
    .SE    (se),
    .PEND  (pend)
  );

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0;
    se = 1'b0;
  endtask

  task automatic exp(input string name, input int sel, input logic [DATA_W-1:0] v);
    name_q.push_back(name);
    sel_q.push_back(sel);
    exp_q.push_back(v);
  endtask

  task automatic fire();
    -> chk_ev;
  endtask

  // monitor / scoreboard
  initial begin
    forever begin
      @(chk_ev);
      #1;
      while (exp_q.size() > 0) begin
        logic [DATA_W-1:0] e, act;
        string             n;
        int                s;
        e = exp_q.pop_front();
        s = sel_q.pop_front();
        n = name_q.pop_front();
        case (s)
          S_DR0:   act = dr[0 +: DATA_W];
          S_DR1:   act = dr[DATA_W +: DATA_W];
          S_RB0:   act = DATA_W'(rbusy[0]);
          S_RB1:   act = DATA_W'(rbusy[1]);
          default: act = DATA_W'(pend);
        endcase
        n_tests++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", n, act, e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    ra0 = 5'd5; ra1 = 5'd0;
    wa = '0; wd = '0; sa = '0;
    idle();
    #1;
    exp("reset_dr0", S_DR0, 32'h0);
    exp("reset_pend", S_PEND, 32'd0);
    exp("reset_rbusy0", S_RB0, 32'd0);
    fire();

    cyc(); rst_n = 1'b1;

    // load reg5 and mark it busy
    cyc(); we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; se = 1'b1; sa = 5'd5;
    exp("load5_bypass", S_DR0, 32'hDEADBEEF);
    fire();
    cyc(); idle();
    exp("load5_stored", S_DR0, 32'hDEADBEEF);
    exp("load5_pend", S_PEND, 32'd1);
    exp("load5_rbusy", S_RB0, 32'd1);
    fire();

    // asynchronous clear mid-cycle; requests during reset are ignored
    @(negedge clk); #1;
    rst_n = 1'b0;
    we = 1'b1; wa = 5'd5; wd = 32'h1; se = 1'b1; sa = 5'd5;
    exp("async_dr0", S_DR0, 32'h0);
    exp("async_pend", S_PEND, 32'd0);
    exp("async_rbusy0", S_RB0, 32'd0);
    fire();
    cyc(); rst_n = 1'b1; idle();
    exp("rst_ignore_dr0", S_DR0, 32'h0);
    exp("rst_ignore_pend", S_PEND, 32'd0);
    exp("rst_ignore_rbusy0", S_RB0, 32'd0);
    fire();

    // write-through bypass
    cyc(); we = 1'b1; wa = 5'd7; wd = 32'h1234; ra0 = 5'd7;
    exp("bypass_dr0", S_DR0, 32'h1234);
    exp("bypass_rbusy0", S_RB0, 32'd0);
    fire();
    cyc(); idle();
    exp("stored7_dr0", S_DR0, 32'h1234);
    fire();

    // zero register
    cyc(); we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; se = 1'b1; sa = 5'd0; ra0 = 5'd0;
    exp("zero_same_dr0", S_DR0, 32'h0);
    exp("zero_same_rbusy0", S_RB0, 32'd0);
    exp("zero_same_pend", S_PEND, 32'd0);
    fire();
    cyc(); idle();
    exp("zero_after_dr0", S_DR0, 32'h0);
    exp("zero_after_rbusy0", S_RB0, 32'd0);
    exp("zero_after_pend", S_PEND, 32'd0);
    fire();

    // scoreboard round trip
    cyc(); se = 1'b1; sa = 5'd3;
    cyc(); sa = 5'd4;
    exp("sb_pend_1", S_PEND, 32'd1);
    fire();
    cyc(); sa = 5'd9;
    cyc(); idle(); ra0 = 5'd4; ra1 = 5'd9;
    exp("sb_pend_3", S_PEND, 32'd3);
    exp("sb_rbusy4", S_RB0, 32'd1);
    exp("sb_rbusy9", S_RB1, 32'd1);
    fire();
    cyc(); we = 1'b1; wa = 5'd4; wd = 32'hAAAA;
    exp("sb_mask4", S_RB0, 32'd0);
    exp("sb_fwd4", S_DR0, 32'hAAAA);
    exp("sb_pend_still3", S_PEND, 32'd3);
    fire();
    cyc(); idle();
    exp("sb_pend_2", S_PEND, 32'd2);
    exp("sb_cleared4", S_RB0, 32'd0);
    exp("sb_still9", S_RB1, 32'd1);
    fire();

    // simultaneous set/clear, same address: set wins
    cyc(); se = 1'b1; sa = 5'd6; ra0 = 5'd6;
    cyc(); idle();
    exp("ss_pend_3", S_PEND, 32'd3);
    exp("ss_busy6", S_RB0, 32'd1);
    fire();
    cyc(); se = 1'b1; sa = 5'd6; we = 1'b1; wa = 5'd6; wd = 32'h66;
    exp("ss_mask6", S_RB0, 32'd0);
    exp("ss_fwd6", S_DR0, 32'h66);
    fire();
    cyc(); idle();
    exp("ss_pend_same", S_PEND, 32'd3);
    exp("ss_busy6_kept", S_RB0, 32'd1);
    exp("ss_dr6", S_DR0, 32'h66);
    fire();

    // simultaneous set/clear, different addresses
    cyc(); se = 1'b1; sa = 5'd8; we = 1'b1; wa = 5'd6; wd = 32'h67;
    cyc(); idle(); ra0 = 5'd8; ra1 = 5'd6;
    exp("sd_pend", S_PEND, 32'd3);
    exp("sd_busy8", S_RB0, 32'd1);
    exp("sd_busy6", S_RB1, 32'd0);
    exp("sd_dr6", S_DR1, 32'h67);
    fire();

    // saturation and idempotence
    for (int a = 1; a < 32; a++) begin
      cyc(); se = 1'b1; sa = 5'(a);
    end
    cyc(); se = 1'b1; sa = 5'd10; ra0 = 5'd31; ra1 = 5'd0;
    exp("sat_pend_31", S_PEND, 32'd31);
    fire();
    cyc(); idle();
    exp("sat_reset10_pend", S_PEND, 32'd31);
    exp("sat_busy31", S_RB0, 32'd1);
    exp("sat_zero_rbusy1", S_RB1, 32'd0);
    exp("sat_zero_dr1", S_DR1, 32'h0);
    fire();
    cyc(); we = 1'b1; wa = 5'd0; wd = 32'h5;
    cyc(); idle();
    exp("clr0_pend", S_PEND, 32'd31);
    fire();
    cyc(); we = 1'b1; wa = 5'd12; wd = 32'hC;
    cyc(); idle(); ra0 = 5'd12;
    exp("clr12_pend", S_PEND, 32'd30);
    exp("clr12_rbusy", S_RB0, 32'd0);
    exp("clr12_dr", S_DR0, 32'hC);
    fire();
    cyc(); we = 1'b1; wa = 5'd12; wd = 32'hD;
    cyc(); idle();
    exp("reclr12_pend", S_PEND, 32'd30);
    exp("reclr12_dr", S_DR0, 32'hD);
    fire();

    // final report
    cyc();
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
